// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one external memory port between the instruction-side
// miss path and the data-side load/store unit. One access at a time, strobe held
// until mem_ready, alternating grant under contention, cycle-budget abort.

package memory_arbiter_pkg;
  typedef logic [31:0] regval_t;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
endpackage

module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic    clock,
  input  logic    reset_n,
  input  logic    i_request,
  input  regval_t i_address,
  output logic    i_data_valid,
  output regval_t i_data,
  input  logic    d_read,
  input  logic    d_write,
  input  regval_t d_address,
  input  regval_t d_write_data,
  output logic    d_data_valid,
  output regval_t d_data,
  output regval_t mem_address,
  output logic    mem_read,
  output logic    mem_write,
  output regval_t mem_write_data,
  input  logic    mem_ready,
  input  regval_t mem_read_data,
  output logic    bus_error
);

  // Counter is at least one bit wide so a disabled timeout still elaborates.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW:0] LIMIT   = (CW+1)'(TIMEOUT_CYCLES);
  localparam logic [CW:0] CNT_ONE = (CW+1)'(1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_grant_instr;
  logic          grant_instr;
  logic          grant_write;

  logic          d_pending;
  logic          pick_instr;
  logic          pick_write;
  logic          timeout_hit;
  regval_t       rdata;

  assign d_pending = d_read | d_write;

  // Arbitration: a lone requester wins; on contention the side not served last wins.
  // A simultaneous d_read/d_write is a write.
  always_comb begin
    pick_instr = 1'b0;
    if (i_request && !d_pending)      pick_instr = 1'b1;
    else if (i_request && d_pending)  pick_instr = !last_grant_instr;
    pick_write = !pick_instr && d_write;
  end

  // Abort fires at the end of the N-th strobe cycle; mem_ready in that cycle wins.
  always_comb begin
    timeout_hit = 1'b0;
    if (TIMEOUT_CYCLES != 0)
      timeout_hit = !mem_ready && (({1'b0, cnt} + CNT_ONE) == LIMIT);
    rdata = (mem_ready && !grant_write) ? mem_read_data : '0;
  end

  // Access FSM; every output is a register so strobes cannot glitch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      cnt              <= '0;
      last_grant_instr <= 1'b1;
      grant_instr      <= 1'b0;
      grant_write      <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      mem_read         <= 1'b0;
      mem_write        <= 1'b0;
      i_data_valid     <= 1'b0;
      i_data           <= '0;
      d_data_valid     <= 1'b0;
      d_data           <= '0;
      bus_error        <= 1'b0;
    end else begin
      i_data_valid <= 1'b0;
      d_data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_request || d_pending) begin
            grant_instr      <= pick_instr;
            grant_write      <= pick_write;
            last_grant_instr <= pick_instr;
            mem_address      <= pick_instr ? i_address : d_address;
            mem_write_data   <= pick_write ? d_write_data : '0;
            mem_read         <= !pick_write;
            mem_write        <= pick_write;
            cnt              <= '0;
            state            <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_ready || timeout_hit) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (grant_instr) begin
              i_data_valid <= 1'b1;
              i_data       <= rdata;
            end else begin
              d_data_valid <= 1'b1;
              d_data       <= rdata;
            end
            if (!mem_ready) bus_error <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter (TIMEOUT_CYCLES=4): single read, write,
// contention order, timeout with sticky error, reset mid-access, read+write.

module tb_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        i_request;
  logic [31:0] i_address;
  logic        i_data_valid;
  logic [31:0] i_data;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_address;
  logic [31:0] d_write_data;
  logic        d_data_valid;
  logic [31:0] d_data;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_write_data;
  logic        mem_ready;
  logic [31:0] mem_read_data;
  logic        bus_error;

  int vectors = 0;
  int miscompares = 0;

  memory_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .i_request(i_request), .i_address(i_address),
    .i_data_valid(i_data_valid), .i_data(i_data),
    .d_read(d_read), .d_write(d_write), .d_address(d_address),
    .d_write_data(d_write_data), .d_data_valid(d_data_valid), .d_data(d_data),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_write_data(mem_write_data), .mem_ready(mem_ready),
    .mem_read_data(mem_read_data), .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    i_request = 0; i_address = 0; d_read = 0; d_write = 0;
    d_address = 0; d_write_data = 0; mem_ready = 0; mem_read_data = 0;
    #1;
    check("rst mem_read", {31'd0, mem_read}, 0);
    check("rst mem_write", {31'd0, mem_write}, 0);
    check("rst mem_address", mem_address, 0);
    check("rst i_data_valid", {31'd0, i_data_valid}, 0);
    check("rst d_data_valid", {31'd0, d_data_valid}, 0);
    check("rst i_data", i_data, 0);
    check("rst d_data", d_data, 0);
    check("rst bus_error", {31'd0, bus_error}, 0);
    step(); step();
    reset_n = 1'b1;

    // Single instruction read, ready after 2 strobe cycles.
    i_request = 1; i_address = 32'h100;
    step();
    check("ird strobe1", {31'd0, mem_read}, 1);
    check("ird addr", mem_address, 32'h100);
    step();
    check("ird strobe2", {31'd0, mem_read}, 1);
    mem_ready = 1; mem_read_data = 32'hDEADBEEF;
    step();
    check("ird strobe off", {31'd0, mem_read}, 0);
    check("ird i_valid", {31'd0, i_data_valid}, 1);
    check("ird i_data", i_data, 32'hDEADBEEF);
    check("ird d_valid", {31'd0, d_data_valid}, 0);
    i_request = 0; mem_ready = 0;
    step();
    check("ird pulse end", {31'd0, i_data_valid}, 0);

    // Data write; address change during ACCESS must be ignored.
    d_write = 1; d_address = 32'h2004; d_write_data = 32'h12345678;
    step();
    check("wr strobe", {31'd0, mem_write}, 1);
    check("wr no read", {31'd0, mem_read}, 0);
    check("wr addr", mem_address, 32'h2004);
    check("wr data", mem_write_data, 32'h12345678);
    d_address = 32'hFFFF0000; d_write_data = 32'h0;
    step();
    check("wr addr held", mem_address, 32'h2004);
    check("wr data held", mem_write_data, 32'h12345678);
    mem_ready = 1;
    step();
    check("wr d_valid", {31'd0, d_data_valid}, 1);
    check("wr d_data", d_data, 0);
    check("wr i_valid", {31'd0, i_data_valid}, 0);
    check("wr strobe off", {31'd0, mem_write}, 0);
    d_write = 0; mem_ready = 0;
    step();
    check("wr no error", {31'd0, bus_error}, 0);

    // Contention from reset release: data, instr, data, instr.
    reset_n = 0;
    #1;
    i_request = 1; i_address = 32'hA0; d_read = 1; d_address = 32'hB0;
    mem_ready = 1; mem_read_data = 32'h11111111;
    step();
    reset_n = 1;
    for (int k = 0; k < 4; k++) begin
      mem_read_data = 32'h11111111 + k;
      step();
      check("ct grant addr", mem_address, (k % 2 == 0) ? 32'hB0 : 32'hA0);
      step();
      check("ct d_valid", {31'd0, d_data_valid}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check("ct i_valid", {31'd0, i_data_valid}, (k % 2 == 0) ? 32'd0 : 32'd1);
      check("ct data", (k % 2 == 0) ? d_data : i_data, 32'h11111111 + k);
      if (k == 3) begin
        i_request = 0; d_read = 0; mem_ready = 0;
      end
      step();
    end

    // Timeout: 4 strobe cycles, then zero data and sticky error.
    d_read = 1; d_address = 32'h300; mem_ready = 0; mem_read_data = 32'h99999999;
    for (int k = 0; k < 4; k++) begin
      step();
      check("to strobe", {31'd0, mem_read}, 1);
    end
    step();
    check("to strobe off", {31'd0, mem_read}, 0);
    check("to d_valid", {31'd0, d_data_valid}, 1);
    check("to d_data", d_data, 0);
    check("to bus_error", {31'd0, bus_error}, 1);
    d_read = 0;
    step();
    i_request = 1; i_address = 32'h400; mem_ready = 1; mem_read_data = 32'hCAFEF00D;
    step();
    step();
    check("to next i_valid", {31'd0, i_data_valid}, 1);
    check("to next i_data", i_data, 32'hCAFEF00D);
    check("to error sticky", {31'd0, bus_error}, 1);
    i_request = 0; mem_ready = 0;
    step();

    // Reset in the 2nd ACCESS cycle.
    i_request = 1; i_address = 32'h500;
    step();
    step();
    check("rm strobe before", {31'd0, mem_read}, 1);
    #2 reset_n = 0;
    #1;
    check("rm strobe async", {31'd0, mem_read}, 0);
    check("rm addr async", mem_address, 0);
    check("rm error cleared", {31'd0, bus_error}, 0);
    check("rm i_data cleared", i_data, 0);
    step();
    check("rm no valid", {31'd0, i_data_valid}, 0);
    reset_n = 1; mem_ready = 1; mem_read_data = 32'h55AA55AA;
    step();
    check("rm after strobe", {31'd0, mem_read}, 1);
    check("rm after addr", mem_address, 32'h500);
    step();
    check("rm after i_valid", {31'd0, i_data_valid}, 1);
    check("rm after i_data", i_data, 32'h55AA55AA);
    i_request = 0; mem_ready = 0;
    step();

    // Simultaneous read and write is a write.
    d_read = 1; d_write = 1; d_address = 32'h40; d_write_data = 32'h77;
    step();
    check("rw mem_write", {31'd0, mem_write}, 1);
    check("rw mem_read", {31'd0, mem_read}, 0);
    check("rw addr", mem_address, 32'h40);
    mem_ready = 1;
    step();
    check("rw d_valid", {31'd0, d_data_valid}, 1);
    check("rw d_data", d_data, 0);
    d_read = 0; d_write = 0; mem_ready = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-port memory arbiter that shares the single external memory port between the instruction side (miss requests leaving the instruction cache) and the data side (load/store unit). It grants one requester at a time, holds the memory strobe until the memory acknowledges, and returns read data to the granted requester with a one-cycle valid pulse. It alternates grants under contention and aborts accesses that exceed a cycle budget.

## Interface
- TIMEOUT_CYCLES, default 255: cycles an access may wait for `mem_ready` before abort; 0 disables the timeout.
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- i_request  in  1  instruction-side read request, level, held until `i_data_valid`
- i_address  in  regval_t  instruction-side byte address
- i_data_valid  out  1  one-cycle pulse: `i_data` holds the fetched word
- i_data  out  regval_t  fetched word
- d_read  in  1  data-side read request, level
- d_write  in  1  data-side write request, level
- d_address  in  regval_t  data-side byte address
- d_write_data  in  regval_t  store data
- d_data_valid  out  1  one-cycle pulse: read data valid or write complete
- d_data  out  regval_t  loaded word, 0 for writes
- mem_address  out  regval_t  memory address
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_write_data  out  regval_t  memory write data
- mem_ready  in  1  memory acknowledge: read data valid or write accepted
- mem_read_data  in  regval_t  memory read data
- bus_error  out  1  sticky: set by any timeout, cleared only by reset

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: no strobes. At the clock edge, if any request is pending, latch grant, address, direction, write data; go to ACCESS.
- Arbitration when only one side is pending: that side wins. When both are pending: the side not granted last wins. The `last_grant` register resets to instruction, so data wins the first contention.
- `d_read` and `d_write` both high is treated as a write.
- ACCESS: `mem_read` or `mem_write` is driven from registered state, with `mem_address` and `mem_write_data` held stable. On a `mem_ready` edge:
  - capture `mem_read_data` for reads, or 0 for writes;
  - go to DONE.
- DONE: the granted side's valid is high for exactly one cycle with the registered data; the other side's valid stays 0. Next state is IDLE unconditionally.
- Requester must drop its request by the edge that ends DONE. A request still high in IDLE is a new access.
- Timeout: a cycle counter (width $clog2(TIMEOUT_CYCLES+1)) clears on entry to ACCESS and increments each ACCESS cycle without `mem_ready`. When it reaches TIMEOUT_CYCLES:
  - strobes drop, state goes to DONE, data is 0, `bus_error` is set.
  - If `mem_ready` arrives in the same cycle, the completion wins and there is no error.
- `i_data`/`d_data` hold their last value outside DONE. Only the valid pulses carry meaning.

## Timing
- Reset (asynchronous, immediate): state IDLE; all outputs 0, including `bus_error`, `mem_address`, `i_data` and `d_data`; counter 0; `last_grant` = instruction. A reset during ACCESS discards the transfer with no valid pulse.
- Minimum latency from request-high to valid-high is 2 cycles (IDLE edge, ACCESS with `mem_ready` already high, DONE). Throughput is at most one access per 3 cycles.
- For a timed-out access with TIMEOUT_CYCLES=N, the strobe is high for exactly N cycles.
- Strobe outputs never glitch: they are a registered decode of state.
- Inputs are sampled only at the IDLE→ACCESS edge. Changes to address or data during ACCESS are ignored.

## Test plan
- Single instruction read: `i_address`=0x100, memory returns 0xDEADBEEF with `mem_ready` after 2 ACCESS cycles. Required: `mem_read`=1 for 2 cycles, `mem_address`=0x100, then `i_data_valid` pulses 1 cycle with `i_data`=0xDEADBEEF; `d_data_valid` stays 0.
- Data write: `d_write` with `d_address`=0x2004 and data 0x12345678, `mem_ready` after 1 cycle. Required: `mem_write`=1 with stable address and data, then `d_data_valid` pulses once with `d_data`=0.
- Contention: `i_request` and `d_read` held continuously from reset release through four accesses. Required: grant order is data, instr, data, instr.
- Timeout: TIMEOUT_CYCLES=4, `d_read` with `mem_ready` never asserted. Required: `mem_read` high for exactly 4 cycles, then `d_data_valid` pulses with `d_data`=0, and `bus_error`=1 and stays high through later successful accesses.
- Reset mid-access: drop `reset_n` in the 2nd ACCESS cycle. Required: strobes and all outputs 0 asynchronously, no valid pulse, and after release the first request is serviced normally.
- Simultaneous `d_read`=`d_write`=1 at address 0x40. Required: `mem_write`=1, `mem_read`=0.
